// File: rtl/seg_char_pkg.sv
// Character codes and conversion FSM states shared by the formatter and the anode/multiplex stage.
package seg_char_pkg;

    localparam logic [3:0] CH_MINUS = 4'd10;
    localparam logic [3:0] CH_F     = 4'd11;
    localparam logic [3:0] CH_BLANK = 4'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2
    } fmt_state_e;

endpackage

// File: rtl/dd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the next left shift carries correctly.
module dd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/signed_char_formatter.sv
// Signed binary -> four display character codes via iterative double-dabble; done follows start by IN_W+2 cycles.
// start is only accepted in IDLE (including the done cycle); requests while busy are dropped, char outputs hold between conversions.
module signed_char_formatter
    import seg_char_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int BCD_N = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] value,
    output logic            busy,
    output logic            done,
    output logic [3:0]      char3,
    output logic [3:0]      char2,
    output logic [3:0]      char1,
    output logic [3:0]      char0
);

    localparam int BCD_W = 4 * BCD_N;
    localparam int CNT_W = $clog2(IN_W);

    fmt_state_e       state_q, state_d;
    logic [IN_W-1:0]  mag_q, mag_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic [3:0][3:0]  chars_q, chars_d;
    logic [3:0][3:0]  fmt;

    for (genvar k = 0; k < BCD_N; k++) begin : g_adj
        dd_digit_adj u_adj (
            .d_i (bcd_q[4*k +: 4]),
            .d_o (bcd_adj[4*k +: 4])
        );
    end

    // Range check and leading-zero blanking on the finished BCD result.
    logic [3:0] d3, d2, d1, d0;
    logic       upper_nz;
    logic       in_range;

    always_comb begin
        fmt      = '0;
        d0       = bcd_q[3:0];
        d1       = bcd_q[7:4];
        d2       = bcd_q[11:8];
        d3       = bcd_q[15:12];
        upper_nz = |bcd_q[BCD_W-1:16];
        in_range = neg_q ? (!upper_nz && d3 == 4'd0) : !upper_nz;
        if (!in_range) begin
            fmt = {4{CH_F}};
        end else if (neg_q) begin
            fmt[3] = CH_MINUS;
            fmt[2] = (d2 != 4'd0) ? d2 : CH_BLANK;
            fmt[1] = (d2 != 4'd0 || d1 != 4'd0) ? d1 : CH_BLANK;
            fmt[0] = d0;
        end else begin
            fmt[3] = (d3 != 4'd0) ? d3 : CH_BLANK;
            fmt[2] = (d3 != 4'd0 || d2 != 4'd0) ? d2 : CH_BLANK;
            fmt[1] = (d3 != 4'd0 || d2 != 4'd0 || d1 != 4'd0) ? d1 : CH_BLANK;
            fmt[0] = d0;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        chars_d = chars_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d   = value[IN_W-1];
                    // Two's-complement negate; the most negative value maps to its true magnitude.
                    mag_d   = value[IN_W-1] ? (~value + IN_W'(1)) : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = BCD_W'({bcd_adj, mag_q[IN_W-1]});
                mag_d = mag_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = FORMAT;
                end
            end
            FORMAT: begin
                chars_d = fmt;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            chars_q <= {4{CH_BLANK}};
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            chars_q <= chars_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign char3 = chars_q[3];
    assign char2 = chars_q[2];
    assign char1 = chars_q[1];
    assign char0 = chars_q[0];

endmodule

// File: tb/tb_signed_char_formatter.sv
// Self-checking bench: directed vector table, random values against an arithmetic model, and multi-cycle corner sequences.
module tb_signed_char_formatter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [3:0]  char3, char2, char1, char0;

    int errors = 0;
    int checks = 0;

    signed_char_formatter #(.IN_W(16), .BCD_N(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .char3 (char3),
        .char2 (char2),
        .char1 (char1),
        .char0 (char0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          val;
        logic [15:0] exp;
        string       name;
    } vec_t;

    function automatic logic [15:0] chars_now();
        return {char3, char2, char1, char0};
    endfunction

    // Reference: decimal rendering straight from the display rules.
    function automatic logic [15:0] ref_chars(input int v);
        int m;
        logic [3:0] c3, c2, c1, c0;
        if (v < -999 || v > 9999) return 16'hBBBB;
        m  = (v < 0) ? -v : v;
        c0 = 4'(m % 10);
        c1 = (m >= 10)  ? 4'((m / 10) % 10)  : 4'd12;
        c2 = (m >= 100) ? 4'((m / 100) % 10) : 4'd12;
        if (v < 0) c3 = 4'd10;
        else       c3 = (m >= 1000) ? 4'(m / 1000) : 4'd12;
        return {c3, c2, c1, c0};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enters and leaves in an IDLE cycle (#1 after an edge); on return the DUT is in its done cycle.
    task automatic run_conv(input int v, input logic [15:0] exp, input string name);
        logic [15:0] prev;
        int cyc;
        int busy_n;
        int stable;
        prev  = chars_now();
        start = 1'b1;
        value = 16'(v);
        tick();
        start  = 1'b0;
        cyc    = 1;
        busy_n = 0;
        stable = 1;
        while (!done && cyc < 40) begin
            if (busy) busy_n++;
            if (chars_now() !== prev) stable = 0;
            tick();
            cyc++;
        end
        check({name, " latency"}, cyc, 18);
        check({name, " busy_cycles"}, busy_n, 17);
        check({name, " hold_while_busy"}, stable, 1);
        check({name, " busy_in_done"}, int'(busy), 0);
        check({name, " chars"}, int'(chars_now()), int'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        int   vals[73];
        int   v;
        int   bad_done;
        int   changed;
        logic [15:0] prev;
        logic [15:0] r;

        vecs[0]  = '{10,     16'hCC10, "pos_10"};
        vecs[1]  = '{-32,    16'hAC32, "neg_32"};
        vecs[2]  = '{0,      16'hCCC0, "zero"};
        vecs[3]  = '{-5,     16'hACC5, "neg_5"};
        vecs[4]  = '{9999,   16'h9999, "max_pos"};
        vecs[5]  = '{10000,  16'hBBBB, "over_pos"};
        vecs[6]  = '{-999,   16'hA999, "min_neg"};
        vecs[7]  = '{-1000,  16'hBBBB, "over_neg"};
        vecs[8]  = '{-32768, 16'hBBBB, "most_neg"};
        vecs[9]  = '{32767,  16'hBBBB, "most_pos"};
        vecs[10] = '{7,      16'hCCC7, "pos_7"};
        vecs[11] = '{-100,   16'hA100, "neg_100"};

        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) tick();
        check("reset chars", int'(chars_now()), 16'hCCCC);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);

        reset    = 1'b0;
        changed  = 0;
        bad_done = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (chars_now() !== 16'hCCCC) changed++;
            if (done || busy) bad_done++;
        end
        check("idle chars_hold", changed, 0);
        check("idle no_activity", bad_done, 0);

        run_conv(-194, 16'hA194, "neg_194");

        // Back-to-back: each call starts in the previous done cycle.
        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].val, vecs[i].exp, vecs[i].name);
        end

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                v = int'($urandom_range(11200)) - 1100;
            end else begin
                r = 16'($urandom);
                v = int'($signed(r));
            end
            run_conv(v, ref_chars(v), $sformatf("rand_%0d", v));
        end

        // start held high with value changing every cycle: only IDLE-cycle samples convert.
        bad_done = 0;
        changed  = 0;
        for (int i = 0; i < 73; i++) begin
            r       = 16'($urandom);
            vals[i] = int'($signed(r));
            if (i % 3 == 0) vals[i] = int'($urandom_range(2000)) - 999;
        end
        start = 1'b1;
        value = 16'(vals[0]);
        prev  = chars_now();
        for (int i = 1; i <= 72; i++) begin
            tick();
            if (i % 18 == 0) begin
                check($sformatf("held_start done@%0d", i), int'(done), 1);
                check($sformatf("held_start chars@%0d", i), int'(chars_now()),
                      int'(ref_chars(vals[i-18])));
            end else begin
                if (done) bad_done++;
                if (chars_now() !== prev) changed++;
            end
            prev  = chars_now();
            value = 16'(vals[i]);
            if (i == 72) start = 1'b0;
        end
        check("held_start spurious_done", bad_done, 0);
        check("held_start chars_outside_done", changed, 0);

        // Abort on the 6th SHIFT cycle.
        start = 1'b1;
        value = 16'd1234;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort chars", int'(chars_now()), 16'hCCCC);
        reset    = 1'b0;
        bad_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) bad_done++;
        end
        check("abort no_done", bad_done, 0);
        run_conv(1234, 16'h1234, "after_abort");

        tick();
        check("done_single_pulse", int'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
